// File: rtl/syn_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : syn_md_sequencer
// Description : Break-before-make controller for the sync-mode combiner
//               select lines (soft_d, rt_sw, sw1, sw2). Mode changes arrive
//               over a valid/ready handshake; all selects drop for a dead
//               time, the new pattern is applied, then held for a minimum
//               time before the next request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module syn_md_sequencer #(
    parameter int DEAD_CYCLES = 16,
    parameter int HOLD_CYCLES = 100,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       abort,
    input  logic       soft_in,
    output logic       soft_d,
    output logic       rt_sw,
    output logic       sw1,
    output logic       sw2,
    output logic [1:0] cur_mode,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_SOFT = 2'd1;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    // Select pattern {rt_sw, sw1, sw2} for each mode
    function automatic logic [2:0] mode_pattern(input logic [1:0] m);
        case (m)
            2'd1:    mode_pattern = 3'b001;
            2'd2:    mode_pattern = 3'b110;
            2'd3:    mode_pattern = 3'b011;
            default: mode_pattern = 3'b000;
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       tgt_mode, tgt_mode_nxt;
    logic [1:0]       cur_mode_nxt;
    logic [2:0]       sel, sel_nxt;
    logic             soft_d_nxt;
    logic             busy_nxt;
    logic             req_ready_nxt;

    assign rt_sw = sel[2];
    assign sw1   = sel[1];
    assign sw2   = sel[0];

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tgt_mode  <= MODE_OFF;
            cur_mode  <= MODE_OFF;
            sel       <= 3'b000;
            soft_d    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tgt_mode  <= tgt_mode_nxt;
            cur_mode  <= cur_mode_nxt;
            sel       <= sel_nxt;
            soft_d    <= soft_d_nxt;
            busy      <= busy_nxt;
            req_ready <= req_ready_nxt;
        end
    end

    // Next-state and next-output logic; abort overrides everything
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tgt_mode_nxt  = tgt_mode;
        cur_mode_nxt  = cur_mode;
        sel_nxt       = sel;
        busy_nxt      = busy;
        req_ready_nxt = req_ready;

        if (abort) begin
            state_nxt     = ST_IDLE;
            cnt_nxt       = '0;
            cur_mode_nxt  = MODE_OFF;
            sel_nxt       = 3'b000;
            busy_nxt      = 1'b0;
            req_ready_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A request for the mode already applied is simply consumed
                    if (req_valid && req_ready && (req_mode != cur_mode)) begin
                        tgt_mode_nxt  = req_mode;
                        state_nxt     = ST_BREAK;
                        cnt_nxt       = DEAD_LOAD;
                        sel_nxt       = 3'b000;
                        busy_nxt      = 1'b1;
                        req_ready_nxt = 1'b0;
                    end
                end
                ST_BREAK: begin
                    if (cnt == '0) begin
                        sel_nxt      = mode_pattern(tgt_mode);
                        cur_mode_nxt = tgt_mode;
                        cnt_nxt      = HOLD_LOAD;
                        state_nxt    = ST_HOLD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state_nxt     = ST_IDLE;
                        busy_nxt      = 1'b0;
                        req_ready_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    cnt_nxt       = '0;
                    cur_mode_nxt  = MODE_OFF;
                    sel_nxt       = 3'b000;
                    busy_nxt      = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            endcase
        end

        // soft_d only carries soft_in while SOFT is actually applied, never in BREAK
        soft_d_nxt = (state_nxt != ST_BREAK) && (cur_mode_nxt == MODE_SOFT) && soft_in;
    end

endmodule
`default_nettype wire

// File: tb/tb_syn_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_syn_md_sequencer
// Description : Scoreboard bench for syn_md_sequencer. Stimulus pushes the
//               expected output vector and the edge it must appear on; the
//               monitor pops an entry every time the DUT outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syn_md_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_mode = 2'd0;
    logic       req_ready;
    logic       abort = 1'b0;
    logic       soft_in = 1'b0;
    logic       soft_d;
    logic       rt_sw;
    logic       sw1;
    logic       sw2;
    logic [1:0] cur_mode;
    logic       busy;

    syn_md_sequencer #(
        .DEAD_CYCLES(16),
        .HOLD_CYCLES(100),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_mode (req_mode),
        .req_ready(req_ready),
        .abort    (abort),
        .soft_in  (soft_in),
        .soft_d   (soft_d),
        .rt_sw    (rt_sw),
        .sw1      (sw1),
        .sw2      (sw2),
        .cur_mode (cur_mode),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Rising edges seen so far; stable when sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Observed vector {req_ready, busy, cur_mode, rt_sw, sw1, sw2, soft_d}
    logic [7:0] obs;
    assign obs = {req_ready, busy, cur_mode, rt_sw, sw1, sw2, soft_d};

    localparam logic [7:0] RESET_VEC = 8'b1_0_00_000_0;

    function automatic logic [7:0] mk(input logic rdy, input logic bsy,
                                      input logic [1:0] m, input logic [2:0] p,
                                      input logic sd);
        mk = {rdy, bsy, m, p, sd};
    endfunction

    task automatic push_exp(input int at, input logic [7:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%b required=%b (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output change must match the next scoreboard entry
    logic [7:0] mon_prev = RESET_VEC;
    exp_t       mon_e;
    logic [2:0] rise, fall;
    always @(negedge clk) begin
        if (obs !== mon_prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: actual=%b at cyc %0d required=no change from %b",
                         obs, cyc, mon_prev);
            end else begin
                mon_e = q.pop_front();
                if ((obs !== mon_e.v) || (cyc != mon_e.at)) begin
                    n_bad++;
                    $display("FAIL event: actual=%b at cyc %0d required=%b at cyc %0d",
                             obs, cyc, mon_e.v, mon_e.at);
                end
            end
            if (obs[3:1] !== mon_prev[3:1]) begin
                n_cmp++;
                rise = obs[3:1] & ~mon_prev[3:1];
                fall = mon_prev[3:1] & ~obs[3:1];
                if (((rise != 3'b000) && (fall != 3'b000)) || (obs[3:1] == 3'b111)) begin
                    n_bad++;
                    $display("FAIL overlap: actual sel %b -> %b at cyc %0d required=break-before-make",
                             mon_prev[3:1], obs[3:1], cyc);
                end
            end
            mon_prev = obs;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Issue a mode change from a falling edge; returns the accept edge
    task automatic request(input logic [1:0] m, input logic [1:0] old_m,
                           input logic [2:0] pat, input logic sd_after, output int a);
        req_valid = 1'b1;
        req_mode  = m;
        a = cyc + 1;
        push_exp(a, mk(1'b0, 1'b1, old_m, 3'b000, 1'b0));
        push_exp(a + 16, mk(1'b0, 1'b1, m, pat, sd_after));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int a;
    int a2;

    initial begin
        #1 rst = 1'b1;
        #1 chk("reset_state", obs, RESET_VEC);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // OFF -> RT
        request(2'd2, 2'd0, 3'b110, 1'b0, a);
        push_exp(a + 116, mk(1'b1, 1'b0, 2'd2, 3'b110, 1'b0));
        wait_cyc(a + 118);

        // RT while in RT: consumed, nothing changes
        req_valid = 1'b1;
        req_mode  = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("same_mode", obs, mk(1'b1, 1'b0, 2'd2, 3'b110, 1'b0));

        // RT -> EXT
        request(2'd3, 2'd2, 3'b011, 1'b0, a);
        push_exp(a + 116, mk(1'b1, 1'b0, 2'd3, 3'b011, 1'b0));
        wait_cyc(a + 118);

        // EXT -> SOFT with soft_in high through BREAK
        soft_in = 1'b1;
        request(2'd1, 2'd3, 3'b001, 1'b1, a);
        wait_cyc(a + 20);
        soft_in = 1'b0;
        push_exp(a + 21, mk(1'b0, 1'b1, 2'd1, 3'b001, 1'b0));
        @(negedge clk);
        soft_in = 1'b1;
        push_exp(a + 22, mk(1'b0, 1'b1, 2'd1, 3'b001, 1'b1));
        @(negedge clk);
        soft_in = 1'b0;
        push_exp(a + 23, mk(1'b0, 1'b1, 2'd1, 3'b001, 1'b0));

        // EXT requested all through HOLD; taken on the first IDLE cycle
        wait_cyc(a + 40);
        req_valid = 1'b1;
        req_mode  = 2'd3;
        push_exp(a + 116, mk(1'b1, 1'b0, 2'd1, 3'b001, 1'b0));
        push_exp(a + 117, mk(1'b0, 1'b1, 2'd1, 3'b000, 1'b0));
        a2 = a + 117;
        wait_cyc(a2);
        req_valid = 1'b0;

        // Abort mid-BREAK
        wait_cyc(a2 + 5);
        abort = 1'b1;
        push_exp(a2 + 6, RESET_VEC);
        @(negedge clk);
        abort = 1'b0;

        // Abort together with a request in IDLE: request has no effect
        wait_cyc(a2 + 10);
        abort     = 1'b1;
        req_valid = 1'b1;
        req_mode  = 2'd2;
        @(negedge clk);
        abort     = 1'b0;
        req_valid = 1'b0;
        wait_cyc(a2 + 40);
        chk("abort_with_req", obs, RESET_VEC);

        // Asynchronous reset mid-HOLD
        request(2'd2, 2'd0, 3'b110, 1'b0, a);
        wait_cyc(a + 40);
        @(posedge clk);
        #1;
        push_exp(cyc, RESET_VEC);
        rst = 1'b1;
        #1 chk("async_reset", obs, RESET_VEC);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
